// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared types and constants for the SPI memory responder.
//   spi_mem_state_t : protocol state of the responder FSM
//   CMD_READ/WRITE  : command byte values recognised on the wire
//   SYNC_STAGES     : depth of the input synchronizer chains
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } spi_mem_state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit flip-flop chain synchronizer into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into every stage
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff
  import spi_mem_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {SYNC_STAGES{RST_VAL}};
    else        chain_q <= chain_d;
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 memory device backed by an internal byte array.
// The SPI pins are oversampled in the clk domain (spi_sck <= clk/4).
//   clk, rst_n    : system clock, asynchronous active-low reset
//   spi_cs_n      : chip select from the host, active-low
//   spi_sck       : SPI clock from the host
//   spi_mosi      : serial data from the host
//   spi_miso      : serial data to the host
//   spi_miso_oe   : high while the read data phase drives MISO
//   busy          : high while the synchronized chip select is low
// Commands: 0x03 READ / 0x02 WRITE, then ADDR_W address bits, then a burst
// that auto-increments modulo DEPTH.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);

  logic cs_n_s, sck_s, mosi_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(spi_sck),  .q(sck_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

  spi_mem_state_t    state_q, state_d;
  logic              sck_prev_q, sck_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_write_q, is_write_d;
  logic              load_q, load_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;

  logic [7:0]        mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [7:0]        mem_rdata;
  logic [7:0]        shift_in;

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_n_s & cs_prev_q;
  assign cs_rise  = cs_n_s & ~cs_prev_q;

  // Upper address bits beyond the array size are simply not decoded.
  assign mem_idx   = addr_q[IDX_W-1:0];
  assign mem_rdata = mem[mem_idx];
  assign shift_in  = {shift_q[6:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A chip-select rise overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (cs_fall) state_d = ST_CMD;
        ST_CMD:
          if (sck_rise && bit_cnt_q == CNT_BYTE_LAST) begin
            if (shift_in == CMD_READ || shift_in == CMD_WRITE) state_d = ST_ADDR;
            else                                               state_d = ST_IGNORE;
          end
        ST_ADDR:
          if (sck_rise && bit_cnt_q == CNT_ADDR_LAST)
            state_d = is_write_q ? ST_WRITE : ST_READ;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sck_prev_d = sck_s;
    cs_prev_d  = cs_n_s;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    load_d     = load_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    mem_we     = 1'b0;

    if (cs_rise) begin
      // Abandon the transaction: partial bytes are dropped, MISO released.
      bit_cnt_d = '0;
      shift_d   = '0;
      load_d    = 1'b0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (cs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
          end
        ST_CMD:
          if (sck_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == CNT_BYTE_LAST) begin
              bit_cnt_d  = '0;
              is_write_d = (shift_in == CMD_WRITE);
              addr_d     = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        ST_ADDR:
          if (sck_rise) begin
            addr_d = {addr_q[ADDR_W-2:0], mosi_s};
            if (bit_cnt_q == CNT_ADDR_LAST) begin
              bit_cnt_d = '0;
              load_d    = ~is_write_q;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        ST_READ:
          // The byte is fetched one cycle after the address settles; with
          // sck <= clk/4 this always lands before the next falling edge.
          if (load_q) begin
            shift_d = mem_rdata;
            load_d  = 1'b0;
          end else if (sck_fall) begin
            miso_d    = shift_q[7];
            miso_oe_d = 1'b1;
            shift_d   = {shift_q[6:0], 1'b0};
            if (bit_cnt_q == CNT_BYTE_LAST) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + ADDR_W'(1);
              load_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        ST_WRITE:
          if (sck_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == CNT_BYTE_LAST) begin
              mem_we    = 1'b1;
              bit_cnt_d = '0;
              addr_d    = addr_q + ADDR_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      is_write_q <= 1'b0;
      load_q     <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      load_q     <= load_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= shift_in;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign busy        = ~cs_n_s;

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: drives the responder as an SPI host and compares the
// returned data against a plain byte-array model of the memory.
module tb_spi_mem_responder;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic spi_cs_n;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;

  spi_mem_responder #(.DEPTH(DEPTH), .ADDR_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int half_ns      = 20;

  logic       mon_miso[$];
  logic       mon_oe[$];
  logic [7:0] model_mem[DEPTH];
  logic [7:0] wr_q[$];

  // Sample MISO three clk periods after every SCK fall while selected.
  always @(negedge spi_sck) begin
    if (spi_cs_n === 1'b0) begin
      #30;
      mon_miso.push_back(spi_miso);
      mon_oe.push_back(spi_miso_oe);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      #(half_ns);
      spi_sck = 1'b1;
      #(half_ns);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spiBegin(input logic [7:0] cmd, input logic [23:0] addr);
    mon_miso.delete();
    mon_oe.delete();
    spi_cs_n = 1'b0;
    #40;
    applyStimulus(cmd, 8);
    applyStimulus(addr[23:16], 8);
    applyStimulus(addr[15:8], 8);
    applyStimulus(addr[7:0], 8);
  endtask

  task automatic spiEnd(input string tag);
    #40;
    spi_cs_n = 1'b1;
    #30;
    checkOutput({tag, " idle outputs"}, {29'd0, busy, spi_miso, spi_miso_oe}, 32'd0);
    #50;
  endtask

  task automatic writeBurst(input string tag, input logic [23:0] addr);
    spiBegin(8'h02, addr);
    for (int i = 0; i < wr_q.size(); i++) begin
      applyStimulus(wr_q[i], 8);
      model_mem[(int'(addr) + i) % DEPTH] = wr_q[i];
    end
    spiEnd(tag);
    wr_q.delete();
  endtask

  task automatic readCheck(input string tag, input logic [23:0] addr, input int n);
    logic       pre_oe;
    logic       data_oe;
    logic [7:0] got;
    spiBegin(8'h03, addr);
    for (int i = 0; i < n; i++) applyStimulus(8'($urandom), 8);
    spiEnd(tag);
    pre_oe  = 1'b0;
    data_oe = 1'b1;
    for (int i = 0; i < 31; i++) pre_oe = pre_oe | mon_oe[i];
    for (int i = 31; i < 31 + 8 * n; i++) data_oe = data_oe & mon_oe[i];
    checkOutput({tag, " oe before data"}, {31'd0, pre_oe}, 32'd0);
    checkOutput({tag, " oe during data"}, {31'd0, data_oe}, 32'd1);
    for (int b = 0; b < n; b++) begin
      got = '0;
      for (int j = 0; j < 8; j++) got = {got[6:0], mon_miso[31 + 8 * b + j]};
      checkOutput($sformatf("%s byte%0d", tag, b), {24'd0, got},
                  {24'd0, model_mem[(int'(addr) + b) % DEPTH]});
    end
  endtask

  initial begin
    logic [23:0] addr;
    logic        any_oe;
    int          n;

    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    rst_n    = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset outputs", {29'd0, busy, spi_miso, spi_miso_oe}, 32'd0);
    #8;
    rst_n = 1'b1;
    #40;

    for (int r = 0; r < 2; r++) begin
      half_ns = (r == 0) ? 20 : 80;

      wr_q = '{8'hA5, 8'h3C};
      writeBurst($sformatf("h%0d wr10", half_ns), 24'h000010);
      readCheck($sformatf("h%0d rd10", half_ns), 24'h000010, 2);

      addr = 24'($urandom);
      n    = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
      writeBurst($sformatf("h%0d wr rand", half_ns), addr);
      readCheck($sformatf("h%0d rd rand", half_ns), {12'($urandom), addr[11:0]}, n);

      wr_q = '{8'h11, 8'h22};
      writeBurst($sformatf("h%0d wr wrap", half_ns), 24'h000FFF);
      readCheck($sformatf("h%0d rd wrap", half_ns), 24'h000FFF, 2);
      readCheck($sformatf("h%0d rd zero", half_ns), 24'h000000, 1);

      spiBegin(8'h9F, 24'($urandom));
      for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 8);
      spiEnd($sformatf("h%0d unknown", half_ns));
      any_oe = 1'b0;
      for (int i = 0; i < mon_oe.size(); i++) any_oe = any_oe | mon_oe[i];
      checkOutput($sformatf("h%0d unknown oe", half_ns), {31'd0, any_oe}, 32'd0);
      readCheck($sformatf("h%0d rd after unknown", half_ns), 24'h000010, 1);

      wr_q = '{8'($urandom)};
      writeBurst($sformatf("h%0d wr20", half_ns), 24'h000020);
      spiBegin(8'h02, 24'h000020);
      applyStimulus(8'($urandom), 5);
      spiEnd($sformatf("h%0d abort", half_ns));
      readCheck($sformatf("h%0d rd20", half_ns), 24'h000020, 1);

      spiBegin(8'h03, 24'h000010);
      applyStimulus(8'h00, 3);
      checkOutput($sformatf("h%0d oe before reset", half_ns), {31'd0, spi_miso_oe}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput($sformatf("h%0d async reset", half_ns),
                  {29'd0, busy, spi_miso, spi_miso_oe}, 32'd0);
      #9;
      rst_n    = 1'b1;
      spi_cs_n = 1'b1;
      #60;
      readCheck($sformatf("h%0d rd after reset", half_ns), 24'h000010, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- Synthesizable SPI mode-0 memory responder: the device end of the SPI memory bus driven by tt_um_froith_goldcrest through its uio pins.
- Used in FPGA emulation builds and the top-level bench as the external memory the core fetches from and stores to.
- Oversamples the SPI pins in the system clock domain and backs them with an internal byte array.
- Supports READ (0x03) and WRITE (0x02), each with a 24-bit address and an auto-incrementing burst.

Parameters:
- DEPTH, 4096, number of bytes in the backing array; must be a power of two.
- ADDR_W, 24, address bits sent on the wire after the command byte.

Ports:
- clk  input  1  system clock; spi_sck must be at most clk/4.
- rst_n  input  1  reset, asynchronous, active-low.
- spi_cs_n  input  1  chip select, active-low; asynchronous to clk.
- spi_sck  input  1  SPI clock; asynchronous to clk.
- spi_mosi  input  1  serial data from the host.
- spi_miso  output  1  serial data to the host.
- spi_miso_oe  output  1  high while the responder drives MISO (read data phase only).
- busy  output  1  high while spi_cs_n (synchronized) is low.

Behaviour:
- Input synchronization:
  - spi_cs_n, spi_sck and spi_mosi each pass through a 2-FF synchronizer.
  - SCK rise and fall are single-cycle pulses derived from the synchronized SCK and its previous value.
- Reset values:
  - spi_miso=0, spi_miso_oe=0, busy=0.
  - State IDLE; bit counter, shift register and address register cleared.
  - Array contents are not reset.
- State machine: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - IDLE -> CMD on the synchronized CS falling edge; bit counter cleared.
  - CMD: shift MOSI MSB-first on each SCK rise. After 8 bits, 0x03 -> ADDR(read), 0x02 -> ADDR(write), any other value -> IGNORE.
  - ADDR: shift ADDR_W bits MSB-first. Array index = addr[log2(DEPTH)-1:0]; upper bits are ignored. After the last bit go to READ or WRITE.
  - READ:
    - Preload the shift register with mem[index] on the cycle after the last address bit.
    - The first SCK fall after that drives bit 7 and sets miso_oe=1.
    - Each following SCK fall drives the next bit. After bit 0, the next fall drives bit 7 of mem[index+1].
    - Required latency: spi_miso valid no later than 3 clk after the raw SCK falling edge (2 sync + 1 reg).
  - WRITE:
    - Shift MOSI on each SCK rise.
    - On the 8th bit, write the byte to mem[index] in the same clk cycle, then increment index.
  - IGNORE: no array access, miso_oe=0; stay until CS rises.
  - Any state -> IDLE on the synchronized CS rising edge. In the same cycle: miso_oe=0, miso=0, partial bytes discarded, no array write.
- Wrap-around: the index increments modulo DEPTH, so bursts past DEPTH-1 continue at 0 for both read and write.
- Simultaneous events: a CS rise in the same cycle as the 8th write bit does not perform the write. CS has priority.
- Reset mid-transaction returns to the reset values immediately (asynchronous). The host must reissue the command.
- SCK edges while CS is high are ignored.
- CS low with no SCK edges holds state indefinitely.

Decomposition:
- Package spi_mem_pkg:
  - state enum spi_mem_state_t;
  - command constants CMD_READ=8'h03, CMD_WRITE=8'h02;
  - SYNC_STAGES=2.
- Sub-module sync_2ff (1-bit, async active-low reset, reset value parameter), instantiated three times.
  - cs_n resets to 1; sck and mosi reset to 0.
- Backing array is inferred in the top module, single write port and single read port.

Test Plan:
- Write then read:
  - Stimulus: CS low, send 02 00 00 10 A5 3C, CS high; then send 03 00 00 10 and clock 16 bits.
  - Required: MISO returns A5 then 3C; miso_oe is high only during the 16 data bits.
- Write wrap-around (DEPTH=4096):
  - Stimulus: write 11 22 at address 0x000FFF; then read 2 bytes from 0x000FFF, and 1 byte from 0x000000.
  - Required: reads return 11 22, and 22 respectively.
- Unknown command:
  - Stimulus: send 9F plus 32 SCK cycles.
  - Required: miso_oe stays 0; the array is unchanged when mem[0x10] is read back afterwards.
- Aborted write:
  - Stimulus: send 02 00 00 20 followed by 5 data bits, then CS high.
  - Required: mem[0x20] keeps its prior value; state returns to IDLE; busy=0 within 3 clk of CS rising.
- Mid-read reset:
  - Stimulus: assert rst_n=0 for 1 clk during a read.
  - Required: miso=0 and miso_oe=0 asynchronously; a new 03 transaction after release returns correct data.
- Clock-ratio stress:
  - Stimulus: run all of the above at SCK = clk/4 and clk/16.
  - Required: identical data at both ratios.
